// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared external 4-bit ALU.
// Optional macro ALU_ARB_MUL_EN adds a 4-step shift-and-add multiply on opcode 101.
module alu_arb_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_out,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant, grant_id;
  logic [3:0] op_a, op_b;
  logic [2:0] op_sel;
  logic       op_id;
  logic       op_done;

`ifdef ALU_ARB_MUL_EN
  logic [1:0] mul_cnt;
  logic [3:0] mul_acc;
  logic       mul_ovf;
  logic       is_mul;
  logic [1:0] mul_idx;
  logic [3:0] mul_pp;
  logic       mul_trunc;

  assign is_mul    = (op_sel == 3'b101);
  assign mul_idx   = 2'd3 - mul_cnt;
  assign mul_pp    = op_b[mul_idx] ? (op_a << mul_idx) : 4'd0;
  // Partial-product bits shifted past bit 3 mean the full product exceeds 15.
  assign mul_trunc = op_b[mul_idx] && ((op_a >> (3'd4 - {1'b0, mul_idx})) != 4'd0);
  assign op_done   = !is_mul || (mul_cnt == 2'd0);
`else
  assign op_done   = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = 4'd0;
    alu_b      = 4'd0;
    alu_sel    = 3'b000;
    if (req0_valid && req1_valid) begin
      grant    = 1'b1;
      grant_id = ~last_grant;
    end else if (req0_valid || req1_valid) begin
      grant    = 1'b1;
      grant_id = req1_valid;
    end
    case (state)
      IDLE: begin
        if (grant && !rst) begin
          req0_ready = !grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        alu_a   = op_a;
        alu_b   = op_b;
        alu_sel = op_sel;
`ifdef ALU_ARB_MUL_EN
        if (is_mul) begin
          alu_a   = mul_acc;
          alu_b   = mul_pp;
          alu_sel = 3'b011;
        end
`endif
        if (op_done) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_a       <= 4'd0;
      op_b       <= 4'd0;
      op_sel     <= 3'b000;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= 4'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARB_MUL_EN
      mul_cnt    <= 2'd0;
      mul_acc    <= 4'd0;
      mul_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a       <= grant_id ? req1_a   : req0_a;
            op_b       <= grant_id ? req1_b   : req0_b;
            op_sel     <= grant_id ? req1_sel : req0_sel;
            op_id      <= grant_id;
            last_grant <= grant_id;
`ifdef ALU_ARB_MUL_EN
            mul_cnt    <= 2'd3;
            mul_acc    <= 4'd0;
            mul_ovf    <= 1'b0;
`endif
          end
        end
        EXEC: begin
`ifdef ALU_ARB_MUL_EN
          if (is_mul && !op_done) begin
            mul_acc <= alu_out;
            mul_ovf <= mul_ovf | alu_carry | mul_trunc;
            mul_cnt <= mul_cnt - 2'd1;
          end
`endif
          if (op_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_out   <= alu_out;
            rsp_carry <= alu_carry;
            rsp_zero  <= alu_zero;
`ifdef ALU_ARB_MUL_EN
            if (is_mul) begin
              rsp_carry <= mul_ovf | alu_carry | mul_trunc;
              rsp_zero  <= (alu_out == 4'd0);
            end
`endif
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Self-checking bench for alu_arb_ctrl: directed scenarios then random traffic,
// checked against a transaction-level reference model (honours ALU_ARB_MUL_EN).
module tb_alu_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_zero;
  logic [3:0] rsp_out;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_carry, alu_zero;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit         m_idle = 1'b1;
  bit         m_pend = 1'b0;
  bit         m_last = 1'b1;
  int         m_left = 0;
  logic [5:0] m_exp  = '0;

  always #5 clk = ~clk;

  alu_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  // shared external ALU
  always_comb begin
    alu_out   = 4'd0;
    alu_carry = 1'b0;
    case (alu_sel)
      3'd0: alu_out = alu_a & alu_b;
      3'd1: alu_out = alu_a | alu_b;
      3'd2: alu_out = alu_a ^ alu_b;
      3'd3: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd4: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_out = 4'd0;
    endcase
    alu_zero = (alu_out == 4'd0);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // expected {out, carry, zero}
  function automatic logic [5:0] ref_rsp(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    int ia, ib, s, o, c;
    ia = int'(a);
    ib = int'(b);
    o  = 0;
    c  = 0;
    case (sel)
      3'd0: o = ia & ib;
      3'd1: o = ia | ib;
      3'd2: o = ia ^ ib;
      3'd3: begin s = ia + ib; o = s % 16; c = (s > 15) ? 1 : 0; end
      3'd4: begin s = ia - ib + 16; o = s % 16; c = (ia < ib) ? 1 : 0; end
`ifdef ALU_ARB_MUL_EN
      3'd5: begin s = ia * ib; o = s % 16; c = (s > 15) ? 1 : 0; end
`endif
      default: o = 0;
    endcase
    ref_rsp = {o[3:0], c[0], (o == 0)};
  endfunction

  function automatic int op_latency(input logic [2:0] sel);
`ifdef ALU_ARB_MUL_EN
    op_latency = (sel == 3'd5) ? 4 : 1;
`else
    op_latency = (sel == 3'd5) ? 1 : 1;
`endif
  endfunction

  task automatic cycle(input bit v0, input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] s0,
                       input bit v1, input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] s1,
                       input bit rr);
    bit grant, gid;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    rsp_ready  = rr;
    #1;
    grant = m_idle && (v0 || v1);
    gid   = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", req0_ready, grant && !gid);
    chk("req1_ready", req1_ready, grant && gid);
    chk("rsp_valid", rsp_valid, m_pend);
    if (m_pend) begin
      chk("rsp_out", rsp_out, m_exp[5:2]);
      chk("rsp_carry", rsp_carry, m_exp[1]);
      chk("rsp_zero", rsp_zero, m_exp[0]);
    end
    if (m_idle || m_pend) chk("alu_quiet", {alu_a, alu_b, alu_sel}, 0);
    @(posedge clk);
    #1;
    if (m_idle) begin
      if (grant) begin
        m_idle = 1'b0;
        m_last = gid;
        m_left = gid ? op_latency(s1) : op_latency(s0);
        m_exp  = gid ? ref_rsp(a1, b1, s1) : ref_rsp(a0, b0, s0);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_pend = 1'b1;
    end else if (m_pend && rr) begin
      m_pend = 1'b0;
      m_idle = 1'b1;
    end
  endtask

  task automatic idle_cyc(input bit rr);
    cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd0, 4'd0, 3'd0, rr);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_rsp_out", rsp_out, 0);
    m_idle = 1'b1; m_pend = 1'b0; m_left = 0; m_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    rst_pulse();

    // ADD 9+8 from req0
    cycle(1, 9, 8, 3, 0, 0, 0, 0, 1);
    idle_cyc(1);
    chk("add_valid", rsp_valid, 1);
    chk("add_out", rsp_out, 1);
    chk("add_carry", rsp_carry, 1);
    chk("add_zero", rsp_zero, 0);
    chk("add_id", rsp_id, 0);
    idle_cyc(1);

    // tie from reset: req0 first, then req1 on the next tie
    rst_pulse();
    cycle(1, 3, 5, 4, 1, 15, 0, 0, 1);
    cycle(1, 3, 5, 4, 1, 15, 0, 0, 1);
    chk("tie_a_id", rsp_id, 0);
    chk("tie_a_out", rsp_out, 4'he);
    chk("tie_a_carry", rsp_carry, 1);
    cycle(1, 3, 5, 4, 1, 15, 0, 0, 1);
    cycle(1, 3, 5, 4, 1, 15, 0, 0, 1);
    cycle(1, 3, 5, 4, 1, 15, 0, 0, 1);
    chk("tie_b_id", rsp_id, 1);
    chk("tie_b_out", rsp_out, 0);
    chk("tie_b_zero", rsp_zero, 1);
    idle_cyc(1);

    // backpressure hold
    cycle(0, 0, 0, 0, 1, 5, 5, 2, 0);
    idle_cyc(0);
    repeat (4) begin
      cycle(1, 1, 1, 0, 1, 1, 1, 0, 0);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, 1);
      chk("hold_out", rsp_out, 0);
      chk("hold_zero", rsp_zero, 1);
    end
    idle_cyc(1);
    chk("hold_release", rsp_valid, 0);

    // reset in EXEC aborts
    cycle(1, 1, 2, 1, 0, 0, 0, 0, 1);
    rst_pulse();
    chk("abort_no_rsp", rsp_valid, 0);
    cycle(1, 2, 3, 3, 1, 4, 4, 1, 1);
    idle_cyc(1);
    chk("abort_next_id", rsp_id, 0);
    chk("abort_next_out", rsp_out, 5);
    idle_cyc(1);

`ifdef ALU_ARB_MUL_EN
    cycle(1, 3, 5, 5, 0, 0, 0, 0, 1);
    repeat (3) begin
      idle_cyc(1);
      chk("mul_busy", rsp_valid, 0);
    end
    idle_cyc(1);
    chk("mul35_valid", rsp_valid, 1);
    chk("mul35_out", rsp_out, 4'hf);
    chk("mul35_carry", rsp_carry, 0);
    idle_cyc(1);
    cycle(1, 7, 3, 5, 0, 0, 0, 0, 1);
    repeat (4) idle_cyc(1);
    chk("mul73_out", rsp_out, 5);
    chk("mul73_carry", rsp_carry, 1);
    idle_cyc(1);
`else
    cycle(1, 3, 5, 5, 0, 0, 0, 0, 1);
    idle_cyc(1);
    chk("op5_valid", rsp_valid, 1);
    chk("op5_out", rsp_out, 0);
    chk("op5_zero", rsp_zero, 1);
    idle_cyc(1);
`endif

    // unused opcode 111
    cycle(0, 0, 0, 0, 1, 15, 15, 7, 1);
    idle_cyc(1);
    chk("op7_out", rsp_out, 0);
    chk("op7_carry", rsp_carry, 0);
    chk("op7_zero", rsp_zero, 1);
    idle_cyc(1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst_pulse();
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
